// File: rtl/mem_ctrl_burst.sv
// mem_ctrl_burst: word memory model with byte enables, wait-states and four-phase incrementing bursts
module mem_ctrl_burst #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 30,
    parameter int MEM_DEPTH   = 65536,
    parameter int LEN_WIDTH   = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic [ADDR_WIDTH-1:0]   ADDR,
    input  logic [DATA_WIDTH-1:0]   DATA_IN,
    input  logic [DATA_WIDTH/8-1:0] MEM_BE,
    input  logic [LEN_WIDTH-1:0]    MEM_LEN,
    input  logic                    MEM_REQ,
    input  logic                    MEM_WRITE,
    output logic [DATA_WIDTH-1:0]   DATA_OUT,
    output logic                    MEM_ACK_OUT,
    output logic                    MEM_ERR,
    output logic                    MEM_LAST
);
    localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam int BW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [7:0] WLAST = 8'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, CLEAR, NEXT} state_t;
    localparam state_t GO = WAIT_CYCLES > 0 ? WAIT : ACCESS;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};
    state_t                state, state_n;
    logic                  req_q, wr_q, wr_n;
    logic [IW-1:0]         addr, addr_n;
    logic [LEN_WIDTH-1:0]  cnt, cnt_n;
    logic [7:0]            wcnt, wcnt_n;
    logic                  ack_n, err_n, last_n;
    logic [DATA_WIDTH-1:0] dout_n;
    logic [ADDR_WIDTH:0]   end_w;
    logic                  in_range, do_wr;

    assign end_w    = {1'b0, ADDR} + (ADDR_WIDTH + 1)'(MEM_LEN);
    assign in_range = end_w < DEPTH_W;
    // a reset arriving at the ACCESS edge suppresses the write
    assign do_wr    = state == ACCESS && wr_q && RESETn;

    always_comb begin
        state_n = state;
        addr_n  = addr;
        cnt_n   = cnt;
        wcnt_n  = wcnt;
        wr_n    = wr_q;
        ack_n   = MEM_ACK_OUT;
        err_n   = MEM_ERR;
        last_n  = MEM_LAST;
        dout_n  = DATA_OUT;
        case (state)
            IDLE: if (req_q) begin
                addr_n  = ADDR[IW-1:0];
                cnt_n   = MEM_LEN;
                wr_n    = MEM_WRITE;
                wcnt_n  = '0;
                state_n = in_range ? GO : CLEAR;
                ack_n   = !in_range;
                err_n   = !in_range;
                last_n  = !in_range;
            end
            WAIT: begin
                wcnt_n  = wcnt == WLAST ? '0 : wcnt + 8'd1;
                state_n = wcnt == WLAST ? ACCESS : WAIT;
            end
            ACCESS: begin
                dout_n  = wr_q ? DATA_OUT : mem[addr];
                ack_n   = 1'b1;
                err_n   = 1'b0;
                last_n  = cnt == '0;
                state_n = CLEAR;
            end
            CLEAR: if (!req_q) begin
                ack_n   = 1'b0;
                err_n   = 1'b0;
                last_n  = 1'b0;
                state_n = MEM_LAST ? IDLE : NEXT;
                addr_n  = MEM_LAST ? addr : addr + IW'(1);
                cnt_n   = MEM_LAST ? cnt : cnt - LEN_WIDTH'(1);
            end
            NEXT: if (req_q) begin
                wcnt_n  = '0;
                state_n = GO;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr        <= '0;
            cnt         <= '0;
            wcnt        <= '0;
            DATA_OUT    <= '0;
            MEM_ACK_OUT <= 1'b0;
            MEM_ERR     <= 1'b0;
            MEM_LAST    <= 1'b0;
        end else begin
            state       <= state_n;
            req_q       <= MEM_REQ;
            wr_q        <= wr_n;
            addr        <= addr_n;
            cnt         <= cnt_n;
            wcnt        <= wcnt_n;
            DATA_OUT    <= dout_n;
            MEM_ACK_OUT <= ack_n;
            MEM_ERR     <= err_n;
            MEM_LAST    <= last_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr)
            for (int i = 0; i < BW; i++)
                if (MEM_BE[i])
                    mem[addr][8*i +: 8] <= DATA_IN[8*i +: 8];
    end
endmodule

// File: tb/tb_mem_ctrl_burst.sv
// tb_mem_ctrl_burst: scoreboard bench driving single words, bursts, errors, wait-states and reset
module tb_mem_ctrl_burst;
    logic        CLK = 0;
    logic        RESETn;
    logic [29:0] ADDR;
    logic [31:0] DATA_IN;
    logic [3:0]  MEM_BE;
    logic [3:0]  MEM_LEN;
    logic        req, req_w;
    logic        MEM_WRITE;
    logic [31:0] dout, dout_w;
    logic        ack, ack_w, err, err_w, last, last_w;

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic        l;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [longint];
    logic [31:0] last_rd [2];
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    mem_ctrl_burst dut (
        .CLK(CLK), .RESETn(RESETn), .ADDR(ADDR), .DATA_IN(DATA_IN), .MEM_BE(MEM_BE),
        .MEM_LEN(MEM_LEN), .MEM_REQ(req), .MEM_WRITE(MEM_WRITE), .DATA_OUT(dout),
        .MEM_ACK_OUT(ack), .MEM_ERR(err), .MEM_LAST(last)
    );

    mem_ctrl_burst #(.WAIT_CYCLES(3)) dut_w (
        .CLK(CLK), .RESETn(RESETn), .ADDR(ADDR), .DATA_IN(DATA_IN), .MEM_BE(MEM_BE),
        .MEM_LEN(MEM_LEN), .MEM_REQ(req_w), .MEM_WRITE(MEM_WRITE), .DATA_OUT(dout_w),
        .MEM_ACK_OUT(ack_w), .MEM_ERR(err_w), .MEM_LAST(last_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] m, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? d[8*b +: 8] : m[8*b +: 8];
        return r;
    endfunction

    task automatic xfer(input int sel, input bit wr, input int a, input logic [3:0] len, input bit first,
                        input logic [31:0] d, input logic [3:0] be, input bit exp_last, input bit exp_err);
        exp_t        x;
        longint      k;
        logic [31:0] m;
        int          n;
        k = longint'(sel) * 64'h4000_0000 + longint'(a);
        m = model.exists(k) ? model[k] : 32'h0;
        x.l = exp_last;
        x.e = exp_err;
        x.lat = exp_err ? 1 : 2 + (sel != 0 ? 3 : 0);
        if (exp_err) x.d = last_rd[sel];
        else if (wr) begin
            x.d = last_rd[sel];
            model[k] = merge(m, d, be);
        end else begin
            x.d = m;
            last_rd[sel] = m;
        end
        sb.push_back(x);
        @(negedge CLK);
        ADDR      = first ? 30'(a) : '0;
        MEM_LEN   = first ? len : 4'hF;
        MEM_WRITE = first ? wr : !wr;
        DATA_IN   = d;
        MEM_BE    = be;
        if (sel != 0) req_w = 1; else req = 1;
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (!(sel != 0 ? ack_w : ack) && n < 50);
        x = sb.pop_front();
        check("ack", sel != 0 ? ack_w : ack, 1);
        check("latency", n - 1, x.lat);
        check("data_out", sel != 0 ? dout_w : dout, x.d);
        check("err", sel != 0 ? err_w : err, x.e);
        check("last", sel != 0 ? last_w : last, x.l);
        repeat (2) @(posedge CLK);
        #1 check("ack_hold", sel != 0 ? ack_w : ack, 1);
        @(negedge CLK);
        req = 0;
        req_w = 0;
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while ((sel != 0 ? ack_w : ack) && n < 50);
        check("ack_drop", sel != 0 ? ack_w : ack, 0);
        check("err_drop", sel != 0 ? err_w : err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESETn = 0; req = 0; req_w = 0; ADDR = '0; DATA_IN = '0; MEM_BE = '0; MEM_LEN = '0; MEM_WRITE = 0;
        last_rd[0] = 0;
        last_rd[1] = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_last", last, 0);
        check("rst_data", dout, 0);
        @(negedge CLK);
        RESETn = 1;

        xfer(0, 1, 5, 0, 1, 32'hDEADBEEF, 4'hF, 1, 0);
        xfer(0, 0, 5, 0, 1, 32'h0, 4'h0, 1, 0);
        check("single_rd", dout, 32'hDEADBEEF);

        xfer(0, 1, 7, 0, 1, 32'h11223344, 4'hF, 1, 0);
        xfer(0, 1, 7, 0, 1, 32'hAABBCCDD, 4'b0101, 1, 0);
        xfer(0, 0, 7, 0, 1, 32'h0, 4'h0, 1, 0);
        check("be_rd", dout, 32'h11BB33DD);
        xfer(0, 1, 7, 0, 1, 32'hFFFFFFFF, 4'h0, 1, 0);
        xfer(0, 0, 7, 0, 1, 32'h0, 4'h0, 1, 0);

        for (int i = 0; i < 4; i++) xfer(0, 1, 100 + i, 3, i == 0, i + 1, 4'hF, i == 3, 0);
        for (int i = 0; i < 4; i++) xfer(0, 0, 100 + i, 3, i == 0, 32'h0, 4'hF, i == 3, 0);
        check("burst_rd_last", dout, 32'd4);

        xfer(0, 1, 65534, 0, 1, 32'hCAFEF00D, 4'hF, 1, 0);
        xfer(0, 1, 65534, 2, 1, 32'h0BAD0BAD, 4'hF, 1, 1);
        xfer(0, 0, 65534, 0, 1, 32'h0, 4'h0, 1, 0);
        check("err_no_write", dout, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) xfer(0, 0, 65532 + i, 3, i == 0, 32'h0, 4'h0, i == 3, 0);
        xfer(0, 0, 32'h3FFF_FFFF, 4'hF, 1, 32'h0, 4'h0, 1, 1);
        xfer(0, 1, 32'h0001_0000, 0, 1, 32'h1, 4'hF, 1, 1);

        xfer(1, 1, 9, 0, 1, 32'h12345678, 4'hF, 1, 0);
        xfer(1, 0, 9, 0, 1, 32'h0, 4'h0, 1, 0);
        check("wait_rd", dout_w, 32'h12345678);

        xfer(0, 1, 200, 2, 1, 32'hA5A50001, 4'hF, 0, 0);
        @(negedge CLK);
        RESETn = 0;
        #1;
        check("mid_rst_state", 64'(dut.state), 0);
        check("mid_rst_ack", ack, 0);
        check("mid_rst_last", last, 0);
        check("mid_rst_data", dout, 0);
        last_rd[0] = 0;
        last_rd[1] = 0;
        @(negedge CLK);
        RESETn = 1;
        xfer(0, 0, 200, 0, 1, 32'h0, 4'h0, 1, 0);
        check("rst_word1", dout, 32'hA5A50001);
        xfer(0, 0, 201, 0, 1, 32'h0, 4'h0, 1, 0);
        check("rst_word2", dout, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
